count_step_decoder: RTL and testbench

- Receive-side companion to the sync up/down counter: samples a counter's count bus and decodes each cycle's transition into up / down / hold / wrap / illegal events.
- Tracks current direction and run length with a small FSM, and keeps a sticky error flag.
- Sits beside the counter as a protocol decoder and monitor; its outputs can rebuild the counter's enable/up controls or drive a scoreboard.

---
 rtl/count_step_pkg.sv | 32 +++
 rtl/step_classifier.sv | 36 +++
 rtl/count_step_decoder.sv | 144 ++++++++++++++
 tb/tb_count_step_decoder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/count_step_pkg.sv
// Shared types for counter-step monitors: FSM state, step kind and event bundle.
// Purely declarative; no latency or backpressure.
package count_step_pkg;

  localparam logic [1:0] DIR_INIT  = 2'd0;
  localparam logic [1:0] DIR_STILL = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT  = DIR_INIT,
    ST_STILL = DIR_STILL,
    ST_UP    = DIR_UP,
    ST_DOWN  = DIR_DOWN
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  typedef struct packed {
    logic step_up;
    logic step_down;
    logic hold;
    logic wrap;
    logic illegal;
  } ev_t;

endpackage

// File: rtl/step_classifier.sv
// Classifies prev->cur of a modulo-2^WIDTH counter as hold/up/down/illegal, plus wrap.
// Combinational, zero latency; no backpressure.
module step_classifier
  import count_step_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output step_e            kind,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [WIDTH-1:0] delta;

  always_comb begin
    delta = cur - prev;
    kind  = STEP_ILLEGAL;
    wrap  = 1'b0;
    // Up is tested before down so that for WIDTH=1 a delta of 1 reads as +1.
    if (delta == ZERO) begin
      kind = STEP_HOLD;
    end else if (delta == ONE) begin
      kind = STEP_UP;
      wrap = (WIDTH == 1) || ((prev == MAX) && (cur == ZERO));
    end else if (delta == MAX) begin
      kind = STEP_DOWN;
      wrap = (prev == ZERO) && (cur == MAX);
    end
  end

endmodule

// File: rtl/count_step_decoder.sv
// Decodes a sampled counter bus into registered up/down/hold/wrap/illegal pulses (1 cycle after sample),
// tracks direction and run length, keeps a sticky error; no backpressure. Option: COUNT_STEP_DECODER_REVERSAL_CNT_EN.
module count_step_decoder
  import count_step_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] count,
  input  logic             err_clr,
  output logic             step_up,
  output logic             step_down,
  output logic             hold,
  output logic             wrap,
  output logic             illegal,
  output logic [1:0]       dir,
  output logic [RUN_W-1:0] run_len,
  output logic             err_sticky
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
  ,
  output logic [RUN_W-1:0] rev_cnt
`endif
);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  ev_t              ev_q, ev_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             err_q, err_d;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
  logic [RUN_W-1:0] rev_cnt_q, rev_cnt_d;
`endif

  step_e cls_kind;
  logic  cls_wrap;

  step_classifier #(.WIDTH(WIDTH)) u_cls (
    .prev (prev_count_q),
    .cur  (count),
    .kind (cls_kind),
    .wrap (cls_wrap)
  );

  always_comb begin
    state_d      = state_q;
    prev_count_d = prev_count_q;
    ev_d         = '0;
    run_len_d    = run_len_q;
    err_d        = err_q;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
    rev_cnt_d    = rev_cnt_q;
    if (err_clr) rev_cnt_d = '0;
`endif
    // Clear first so that a same-cycle illegal below re-sets the flag.
    if (err_clr) err_d = 1'b0;

    if (valid) begin
      prev_count_d = count;
      if (state_q == ST_INIT) begin
        state_d   = ST_STILL;
        run_len_d = '0;
      end else begin
        case (cls_kind)
          STEP_UP: begin
            ev_d.step_up = 1'b1;
            ev_d.wrap    = cls_wrap;
            state_d      = ST_UP;
            if (state_q == ST_UP)
              run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_ONE;
            else
              run_len_d = RUN_ONE;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
            if (state_q == ST_DOWN && rev_cnt_d != RUN_MAX) rev_cnt_d = rev_cnt_d + RUN_ONE;
`endif
          end
          STEP_DOWN: begin
            ev_d.step_down = 1'b1;
            ev_d.wrap      = cls_wrap;
            state_d        = ST_DOWN;
            if (state_q == ST_DOWN)
              run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_ONE;
            else
              run_len_d = RUN_ONE;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
            if (state_q == ST_UP && rev_cnt_d != RUN_MAX) rev_cnt_d = rev_cnt_d + RUN_ONE;
`endif
          end
          STEP_HOLD: begin
            ev_d.hold = 1'b1;
            state_d   = ST_STILL;
            run_len_d = '0;
          end
          default: begin
            ev_d.illegal = 1'b1;
            state_d      = ST_STILL;
            run_len_d    = '0;
            err_d        = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      prev_count_q <= '0;
      ev_q         <= '0;
      run_len_q    <= '0;
      err_q        <= 1'b0;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
      rev_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prev_count_q <= prev_count_d;
      ev_q         <= ev_d;
      run_len_q    <= run_len_d;
      err_q        <= err_d;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
      rev_cnt_q    <= rev_cnt_d;
`endif
    end
  end

  assign step_up    = ev_q.step_up;
  assign step_down  = ev_q.step_down;
  assign hold       = ev_q.hold;
  assign wrap       = ev_q.wrap;
  assign illegal    = ev_q.illegal;
  assign dir        = state_q;
  assign run_len    = run_len_q;
  assign err_sticky = err_q;
`ifdef COUNT_STEP_DECODER_REVERSAL_CNT_EN
  assign rev_cnt    = rev_cnt_q;
`endif

endmodule

// File: tb/tb_count_step_decoder.sv
// Directed bench for count_step_decoder (WIDTH=4, RUN_W=8, default build).
module tb_count_step_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid;
  logic [3:0] count;
  logic       err_clr;
  logic       step_up, step_down, hold, wrap, illegal;
  logic [1:0] dir;
  logic [7:0] run_len;
  logic       err_sticky;

  int tests = 0;
  int fails = 0;

  count_step_decoder #(.WIDTH(4), .RUN_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      (valid),
    .count      (count),
    .err_clr    (err_clr),
    .step_up    (step_up),
    .step_down  (step_down),
    .hold       (hold),
    .wrap       (wrap),
    .illegal    (illegal),
    .dir        (dir),
    .run_len    (run_len),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // pulse vector order: {step_up, step_down, hold, wrap, illegal}
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] ev, input logic [1:0] d,
                         input logic [7:0] rl, input logic err);
    chk({tag, ".ev"},  {27'd0, step_up, step_down, hold, wrap, illegal}, {27'd0, ev});
    chk({tag, ".dir"}, {30'd0, dir}, {30'd0, d});
    chk({tag, ".run"}, {24'd0, run_len}, {24'd0, rl});
    chk({tag, ".err"}, {31'd0, err_sticky}, {31'd0, err});
  endtask

  task automatic sample(input logic [3:0] c, input logic clr);
    @(negedge clk);
    valid   = 1'b1;
    count   = c;
    err_clr = clr;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    valid   = 1'b0;
    err_clr = clr;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    valid   = 1'b0;
    count   = 4'd0;
    err_clr = 1'b0;
    #12;
    chk_all("reset", 5'b00000, 2'd0, 8'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Plain up-count: first sample silent.
    sample(4'd0, 1'b0); chk_all("up.s0", 5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd1, 1'b0); chk_all("up.s1", 5'b10000, 2'd2, 8'd1, 1'b0);
    sample(4'd2, 1'b0); chk_all("up.s2", 5'b10000, 2'd2, 8'd2, 1'b0);
    sample(4'd3, 1'b0); chk_all("up.s3", 5'b10000, 2'd2, 8'd3, 1'b0);
    idle(1'b0);         chk_all("up.idle", 5'b00000, 2'd2, 8'd3, 1'b0);

    // Up wrap 15->0.
    do_reset();
    sample(4'd14, 1'b0); chk_all("uw.s14", 5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd15, 1'b0); chk_all("uw.s15", 5'b10000, 2'd2, 8'd1, 1'b0);
    sample(4'd0,  1'b0); chk_all("uw.s0",  5'b10010, 2'd2, 8'd2, 1'b0);
    sample(4'd1,  1'b0); chk_all("uw.s1",  5'b10000, 2'd2, 8'd3, 1'b0);

    // Down wrap 0->15.
    do_reset();
    sample(4'd0,  1'b0); chk_all("dw.s0",  5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd15, 1'b0); chk_all("dw.s15", 5'b01010, 2'd3, 8'd1, 1'b0);
    sample(4'd14, 1'b0); chk_all("dw.s14", 5'b01000, 2'd3, 8'd2, 1'b0);

    // Reversal.
    do_reset();
    sample(4'd5, 1'b0); chk_all("rv.s5a", 5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd6, 1'b0); chk_all("rv.s6a", 5'b10000, 2'd2, 8'd1, 1'b0);
    sample(4'd7, 1'b0); chk_all("rv.s7",  5'b10000, 2'd2, 8'd2, 1'b0);
    sample(4'd6, 1'b0); chk_all("rv.s6b", 5'b01000, 2'd3, 8'd1, 1'b0);
    sample(4'd5, 1'b0); chk_all("rv.s5b", 5'b01000, 2'd3, 8'd2, 1'b0);

    // Hold and gaps.
    do_reset();
    sample(4'd9, 1'b0); chk_all("hg.s9a", 5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd9, 1'b0); chk_all("hg.s9b", 5'b00100, 2'd1, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0); chk_all("hg.gap", 5'b00000, 2'd1, 8'd0, 1'b0);
    end
    sample(4'd10, 1'b0); chk_all("hg.s10", 5'b10000, 2'd2, 8'd1, 1'b0);

    // Illegal and sticky error.
    do_reset();
    sample(4'd3, 1'b0); chk_all("il.s3", 5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd4, 1'b0); chk_all("il.s4", 5'b10000, 2'd2, 8'd1, 1'b0);
    sample(4'd7, 1'b0); chk_all("il.s7", 5'b00001, 2'd1, 8'd0, 1'b1);
    idle(1'b0);         chk_all("il.keep", 5'b00000, 2'd1, 8'd0, 1'b1);
    idle(1'b1);         chk_all("il.clr",  5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd0, 1'b0); chk_all("il.s0", 5'b00001, 2'd1, 8'd0, 1'b1);
    idle(1'b1);         chk_all("il.clr2", 5'b00000, 2'd1, 8'd0, 1'b0);
    sample(4'd8, 1'b1); chk_all("il.s8clr", 5'b00001, 2'd1, 8'd0, 1'b1);

    // Run-length saturation: 300 consecutive up steps.
    do_reset();
    sample(4'd0, 1'b0);
    for (int i = 1; i <= 300; i++) sample(4'(i), 1'b0);
    chk_all("sat", 5'b10000, 2'd2, 8'd255, 1'b0);

    // Async reset mid-run.
    do_reset();
    sample(4'd0, 1'b0);
    sample(4'd1, 1'b0);
    sample(4'd2, 1'b0);
    sample(4'd3, 1'b0);
    sample(4'd4, 1'b0); chk_all("ar.pre", 5'b10000, 2'd2, 8'd4, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("ar.now", 5'b00000, 2'd0, 8'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    sample(4'd12, 1'b0); chk_all("ar.s12", 5'b00000, 2'd1, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
